// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter (CPU / VGA / COM).
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int STARVE_W   = 8;

    // Requester that owns the read word returning from the RAM next cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_VGA,
        OWN_COM
    } owner_t;

    // Last of the two round-robin requesters (VGA/COM) that was granted.
    typedef enum logic {
        RR_VGA,
        RR_COM
    } rr_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle of the data-RAM port arbiter.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              com_req;
    logic [ADDR_W-1:0] com_addr;
    logic              com_gnt;
    logic              com_rvalid;
    logic [DATA_W-1:0] com_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    // Requesters and the RAM model sit on the master side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output vga_req, vga_addr,
        input  vga_gnt, vga_rvalid, vga_rdata,
        output com_req, com_addr,
        input  com_gnt, com_rvalid, com_rdata,
        input  ram_addr, ram_data, ram_wren,
        output ram_q
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  vga_req, vga_addr,
        output vga_gnt, vga_rvalid, vga_rdata,
        input  com_req, com_addr,
        output com_gnt, com_rvalid, com_rdata,
        output ram_addr, ram_data, ram_wren,
        input  ram_q
    );

endinterface

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of consecutive VGA wait cycles; limit_hit forces VGA through.
module ram_arb_starve_ctr
    import ram_arb_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_wait,
    output logic o_limit_hit
);
    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] r_count;

    // A grant or a dropped request both show up as i_wait=0 and restart the count.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (!i_wait) begin
            r_count <= '0;
        end else if (r_count != LIMIT_C) begin
            r_count <= r_count + STARVE_W'(1);
        end
    end

    assign o_limit_hit = (r_count == LIMIT_C);

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port data-RAM arbiter: CPU priority, VGA/COM round-robin, 1-cycle read return.
// Define RAM_ARB_STARVE_GUARD_EN to add the VGA starvation override.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus
);
    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("STARVE_MAX must lie in 1..255");
    end

    owner_t            r_own_q;
    owner_t            w_own_d;
    rr_t               r_rr_last;
    rr_t               w_rr_d;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_cpu_gnt;
    logic              w_vga_gnt;
    logic              w_com_gnt;
    logic              w_starve_hit;

`ifdef RAM_ARB_STARVE_GUARD_EN
    ram_arb_starve_ctr #(.LIMIT(STARVE_MAX)) u_starve_ctr (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_wait      (bus.vga_req & ~w_vga_gnt),
        .o_limit_hit (w_starve_hit)
    );
`else
    assign w_starve_hit = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_vga_gnt  = 1'b0;
        w_com_gnt  = 1'b0;
        w_own_d    = OWN_NONE;
        w_rr_d     = r_rr_last;
        w_ram_addr = r_ram_addr;
        if (reset) begin
            if (w_starve_hit && bus.vga_req) begin
                w_vga_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (bus.vga_req && (!bus.com_req || r_rr_last == RR_COM)) begin
                w_vga_gnt = 1'b1;
            end else if (bus.com_req) begin
                w_com_gnt = 1'b1;
            end
        end
        if (w_cpu_gnt) begin
            w_ram_addr = bus.cpu_addr;
            w_own_d    = bus.cpu_we ? OWN_NONE : OWN_CPU;
        end else if (w_vga_gnt) begin
            w_ram_addr = bus.vga_addr;
            w_own_d    = OWN_VGA;
            w_rr_d     = RR_VGA;
        end else if (w_com_gnt) begin
            w_ram_addr = bus.com_addr;
            w_own_d    = OWN_COM;
            w_rr_d     = RR_COM;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_own_q    <= OWN_NONE;
            r_rr_last  <= RR_COM;
            r_ram_addr <= '0;
        end else begin
            r_own_q    <= w_own_d;
            r_rr_last  <= w_rr_d;
            r_ram_addr <= w_ram_addr;
        end
    end

    assign bus.cpu_gnt  = w_cpu_gnt;
    assign bus.vga_gnt  = w_vga_gnt;
    assign bus.com_gnt  = w_com_gnt;
    assign bus.ram_addr = w_ram_addr;
    assign bus.ram_data = bus.cpu_wdata;
    assign bus.ram_wren = w_cpu_gnt & bus.cpu_we;

    // Gating with reset drops a return whose cycle coincides with reset.
    assign w_rdata        = bus.ram_q;
    assign bus.cpu_rvalid = reset && (r_own_q == OWN_CPU);
    assign bus.vga_rvalid = reset && (r_own_q == OWN_VGA);
    assign bus.com_rvalid = reset && (r_own_q == OWN_COM);
    assign bus.cpu_rdata  = w_rdata;
    assign bus.vga_rdata  = w_rdata;
    assign bus.com_rdata  = w_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a RAM model and a read-return scoreboard.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SM = 4;

    typedef struct {
        owner_t        who;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] ram_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    rd_exp_t       sb [$];
    logic [AW-1:0] last_addr = '0;
    int            n_checks  = 0;
    int            n_pass    = 0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {16'hA5A5, a};
    endfunction

    // Registered-output RAM: q reflects the array before this edge's write.
    always @(posedge clk) begin
        bus.ram_q <= ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr] : init_word(bus.ram_addr);
        if (bus.ram_wren) ram_mem[bus.ram_addr] = bus.ram_data;
    end

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [2:0] onehot(input owner_t o);
        case (o)
            OWN_CPU: return 3'b100;
            OWN_VGA: return 3'b010;
            OWN_COM: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: check outputs mid-cycle against the expected grant, update models.
    task automatic tick(input owner_t exp_gnt);
        rd_exp_t       e;
        owner_t        rv_exp = OWN_NONE;
        logic [DW-1:0] rd_exp = '0;
        logic [AW-1:0] a_exp;
        logic          we_exp = 1'b0;
        @(negedge clk);
        if (sb.size() > 0) begin
            e      = sb.pop_front();
            rv_exp = e.who;
            rd_exp = e.data;
        end
        check("rvalid", {bus.cpu_rvalid, bus.vga_rvalid, bus.com_rvalid}, onehot(rv_exp));
        case (rv_exp)
            OWN_CPU: check("cpu_rdata", bus.cpu_rdata, rd_exp);
            OWN_VGA: check("vga_rdata", bus.vga_rdata, rd_exp);
            OWN_COM: check("com_rdata", bus.com_rdata, rd_exp);
            default: ;
        endcase
        check("gnt", {bus.cpu_gnt, bus.vga_gnt, bus.com_gnt}, onehot(exp_gnt));
        a_exp = last_addr;
        case (exp_gnt)
            OWN_CPU: begin a_exp = bus.cpu_addr; we_exp = bus.cpu_we; end
            OWN_VGA: a_exp = bus.vga_addr;
            OWN_COM: a_exp = bus.com_addr;
            default: ;
        endcase
        check("ram_addr", bus.ram_addr, a_exp);
        check("ram_wren", bus.ram_wren, we_exp);
        if (we_exp) check("ram_data", bus.ram_data, bus.cpu_wdata);
        if (exp_gnt != OWN_NONE) begin
            if (we_exp) ref_mem[a_exp] = bus.cpu_wdata;
            else        sb.push_back('{who: exp_gnt, data: ref_rd(a_exp)});
            last_addr = a_exp;
        end
        @(posedge clk);
        #1;
        if (!reset) last_addr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every requester active: no grants, outputs at reset values.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0005; bus.cpu_wdata = 32'h1111_1111;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0100;
        bus.com_req = 1'b1; bus.com_addr = 16'h0200;
        tick(OWN_NONE);
        tick(OWN_NONE);
        bus.cpu_req = 1'b0; bus.vga_req = 1'b0; bus.com_req = 1'b0;
        reset = 1'b1;
        tick(OWN_NONE);

        // VGA/COM round-robin, VGA first after reset.
        bus.vga_req = 1'b1; bus.com_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick((i % 2 == 0) ? OWN_VGA : OWN_COM);
            if (i % 2 == 0) bus.vga_addr = bus.vga_addr + 16'd1;
            else            bus.com_addr = bus.com_addr + 16'd1;
        end
        bus.vga_req = 1'b0; bus.com_req = 1'b0;
        tick(OWN_NONE);

        // CPU write then read-back of the same word.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 32'hDEAD_BEEF;
        tick(OWN_CPU);
        bus.cpu_we = 1'b0;
        tick(OWN_CPU);
        bus.cpu_req = 1'b0;
        tick(OWN_NONE);

        // All three at once: CPU wins, then VGA, then COM.
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0110;
        bus.com_req = 1'b1; bus.com_addr = 16'h0210;
        tick(OWN_CPU);
        bus.cpu_req = 1'b0;
        tick(OWN_VGA);
        bus.vga_req = 1'b0;
        tick(OWN_COM);
        bus.com_req = 1'b0;
        tick(OWN_NONE);

        // Continuous CPU traffic with VGA waiting.
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0040;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0120;
`ifdef RAM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 10; i++) begin
            tick((i % 5 == 4) ? OWN_VGA : OWN_CPU);
            if (i % 5 == 4) bus.vga_addr = bus.vga_addr + 16'd1;
            else            bus.cpu_addr = bus.cpu_addr + 16'd1;
        end
        for (int i = 0; i < 4; i++) begin
            tick(OWN_CPU);
            bus.cpu_addr = bus.cpu_addr + 16'd1;
        end
        // CPU write pending under the override, then withdrawn without a grant.
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 32'h1234_5678;
        tick(OWN_VGA);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.vga_req = 1'b0;
        tick(OWN_NONE);
`else
        for (int i = 0; i < 12; i++) begin
            tick(OWN_CPU);
            bus.cpu_addr = bus.cpu_addr + 16'd1;
        end
        bus.cpu_req = 1'b0; bus.vga_req = 1'b0;
`endif
        tick(OWN_NONE);

        // VGA read granted, reset in the next cycle drops its return; CPU write pending in reset is lost.
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0150;
        tick(OWN_VGA);
        bus.vga_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 32'hCAFE_F00D;
        reset = 1'b0;
        sb.delete();
        tick(OWN_NONE);
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        tick(OWN_NONE);
        bus.cpu_req = 1'b1;
        tick(OWN_CPU);
        bus.cpu_req = 1'b0;
        tick(OWN_NONE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
